// File: rtl/stack_pkg.sv
// Shared constants and op encoding for the pushdown stack.
package stack_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_DEPTH = 8;

    // Encoded directly as {Push, Pop}.
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } op_e;

endpackage

// File: rtl/stack_dff.sv
// Plain D flip-flop storage cell, no reset (stack contents are don't-care after reset).
module stack_dff (
    input  logic clk_i,
    input  logic d_i,
    output logic q_o
);

    // Capture D on every rising edge.
    always_ff @(posedge clk_i) begin
        q_o <= d_i;
    end

endmodule

// File: rtl/stack_reg_bank.sv
// DEPTH x WIDTH register bank built from stack_dff cells with per-entry hold muxes.
module stack_reg_bank #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic [DEPTH-1:0]         wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic [DEPTH*WIDTH-1:0]   entries_o
);

    logic [DEPTH*WIDTH-1:0] d_bus;

    // Hold mux: an entry reloads its own value unless its enable is set.
    always_comb begin
        d_bus = entries_o;
        for (int e = 0; e < DEPTH; e++) begin
            if (wr_en_i[e]) begin
                d_bus[e*WIDTH +: WIDTH] = wr_data_i;
            end
        end
    end

    for (genvar g = 0; g < DEPTH * WIDTH; g++) begin : g_bit
        stack_dff u_dff (
            .clk_i (clk_i),
            .d_i   (d_bus[g]),
            .q_o   (entries_o[g])
        );
    end

endmodule

// File: rtl/pushdown_stack_ctrl.sv
// LIFO stack controller: op decode, Count register, flags, write enables and top-of-stack mux.
module pushdown_stack_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Push,
    input  logic             Pop,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] DataOut,
    output logic [CW-1:0]    Count,
    output logic             Empty,
    output logic             Full,
    output logic             Overflow,
    output logic             Underflow
);

    logic [CW-1:0]          count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   is_empty, is_full;
    op_e                    op;
    logic                   wr_any;
    logic [CW-1:0]          wr_idx;
    logic [DEPTH-1:0]       wr_en;
    logic [DEPTH*WIDTH-1:0] entries;
    logic [WIDTH-1:0]       top_word;

    // Flags are decoded from the registered count only.
    always_comb begin
        op       = op_e'({Push, Pop});
        is_empty = (count_q == '0);
        is_full  = (count_q == CW'(DEPTH));
    end

    // Op decode: next count, error pulses and the single write target.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        wr_any  = 1'b0;
        wr_idx  = count_q;
        unique case (op)
            OP_NOP: ;
            OP_PUSH: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_any  = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            OP_REPL: begin
                // Replace on a non-empty stack; on an empty one it degenerates to a push.
                wr_any = 1'b1;
                if (is_empty) begin
                    wr_idx  = '0;
                    count_d = CW'(1);
                end else begin
                    wr_idx = count_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    // One-hot (or zero) per-entry load enable.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en[i] = wr_any && (wr_idx == CW'(i));
        end
    end

    // Top-of-stack read mux; zero when empty.
    always_comb begin
        top_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i + 1)) begin
                top_word = entries[i*WIDTH +: WIDTH];
            end
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    stack_reg_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk_i     (Clk),
        .wr_en_i   (wr_en),
        .wr_data_i (DataIn),
        .entries_o (entries)
    );

    assign DataOut   = top_word;
    assign Count     = count_q;
    assign Empty     = is_empty;
    assign Full      = is_full;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule
